// File: rtl/cmp_pkg.sv
// Shared types and helpers for the vector comparator pipeline.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_GT = 2'b00,
    CMP_GE = 2'b01,
    CMP_EQ = 2'b10,
    CMP_LT = 2'b11
  } cmp_mode_e;

  // Width needed to hold a popcount of 0..lanes.
  function automatic int unsigned cnt_w(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic logic apply_mode(input logic gt, input logic eq, input cmp_mode_e mode);
    logic r;
    r = 1'b0;
    unique case (mode)
      CMP_GT:  r = gt;
      CMP_GE:  r = gt | eq;
      CMP_EQ:  r = eq;
      CMP_LT:  r = ~gt & ~eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_vec_pipe_if.sv
// Valid/ready bus carrying operand beats in and flag/count results out.
interface cmp_vec_pipe_if
  import cmp_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned LANES = 4
);
  localparam int unsigned CW = cnt_w(LANES);

  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_flags;
  logic [CW-1:0]      out_count;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_flags, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_flags, out_count
  );
endinterface

// File: rtl/cmp_lane.sv
// Single-lane magnitude/equality compare, unsigned or two's complement.
module cmp_lane #(
  parameter int unsigned W      = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o,
  output logic         eq_o
);

  if (SIGNED) begin : g_signed
    assign gt_o = $signed(a_i) > $signed(b_i);
  end else begin : g_unsigned
    assign gt_o = a_i > b_i;
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_vec_pipe.sv
// Two-stage LANES-wide comparator: stage 1 holds raw gt/eq, stage 2 holds
// mode-applied flags and their popcount.
module cmp_vec_pipe
  import cmp_pkg::*;
#(
  parameter int unsigned W      = 3,
  parameter int unsigned LANES  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  cmp_vec_pipe_if.slave bus
);

  localparam int unsigned CW = cnt_w(LANES);

  logic [LANES-1:0] gt_c;
  logic [LANES-1:0] eq_c;

  logic             v1_q;
  logic [LANES-1:0] gt1_q;
  logic [LANES-1:0] eq1_q;
  cmp_mode_e        mode1_q;

  logic             v2_q;
  logic [LANES-1:0] flags_q;
  logic [LANES-1:0] flags_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic             rdy1;
  logic             rdy2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cmp_lane #(
      .W      (W),
      .SIGNED (SIGNED)
    ) u_lane (
      .a_i  (bus.in_a[i*W +: W]),
      .b_i  (bus.in_b[i*W +: W]),
      .gt_o (gt_c[i]),
      .eq_o (eq_c[i])
    );
  end

  // A stage may advance when it is empty or the stage after it advances.
  assign rdy2         = !v2_q || bus.out_ready;
  assign rdy1         = !v1_q || rdy2;
  assign bus.in_ready = rdy1;

  always_comb begin
    flags_d = '0;
    count_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      flags_d[i] = apply_mode(gt1_q[i], eq1_q[i], mode1_q);
      count_d    = count_d + CW'(flags_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      gt1_q   <= '0;
      eq1_q   <= '0;
      mode1_q <= CMP_GT;
    end else if (rdy1) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        gt1_q   <= gt_c;
        eq1_q   <= eq_c;
        mode1_q <= cmp_mode_e'(bus.in_mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      flags_q <= '0;
      count_q <= '0;
    end else if (rdy2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        flags_q <= flags_d;
        count_q <= count_d;
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_flags = flags_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_cmp_vec_pipe.sv
// Bench driving an unsigned and a signed instance with identical beats and
// checking both against an arithmetic reference model.
module tb_cmp_vec_pipe;

  localparam int unsigned W     = 3;
  localparam int unsigned LANES = 4;

  typedef struct {
    logic [3:0] f0;
    logic [3:0] f1;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic [1:0]  in_mode;
  logic        out_ready;

  int checks;
  int errors;
  exp_t exp_q[$];

  cmp_vec_pipe_if #(.W(W), .LANES(LANES)) u_if0 ();
  cmp_vec_pipe_if #(.W(W), .LANES(LANES)) u_if1 ();

  assign u_if0.in_valid  = in_valid;
  assign u_if0.in_a      = in_a;
  assign u_if0.in_b      = in_b;
  assign u_if0.in_mode   = in_mode;
  assign u_if0.out_ready = out_ready;
  assign u_if1.in_valid  = in_valid;
  assign u_if1.in_a      = in_a;
  assign u_if1.in_b      = in_b;
  assign u_if1.in_mode   = in_mode;
  assign u_if1.out_ready = out_ready;

  cmp_vec_pipe #(.W(W), .LANES(LANES), .SIGNED(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if0.slave)
  );

  cmp_vec_pipe #(.W(W), .LANES(LANES), .SIGNED(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(input logic [11:0] a, input logic [11:0] b,
                                             input logic [1:0] m, input bit sgn);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      int x;
      int y;
      x = int'(a[k*3 +: 3]);
      y = int'(b[k*3 +: 3]);
      if (sgn && x >= 4) x = x - 8;
      if (sgn && y >= 4) y = y - 8;
      case (m)
        2'd0: r[k] = (x > y);
        2'd1: r[k] = (x >= y);
        2'd2: r[k] = (x == y);
        default: r[k] = (x < y);
      endcase
    end
    return r;
  endfunction

  function automatic int popc(input logic [3:0] f);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) n = n + int'(f[k]);
    return n;
  endfunction

  // Scoreboard: record every accepted beat, check every delivered result in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if0.out_valid && out_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected: output beat flags=%b with no outstanding input", u_if0.out_flags);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks = checks + 4;
          if (u_if0.out_flags !== e.f0) begin
            errors = errors + 1;
            $display("FAIL sb_flags_u: got %b want %b", u_if0.out_flags, e.f0);
          end
          if (u_if0.out_count !== 3'(popc(e.f0))) begin
            errors = errors + 1;
            $display("FAIL sb_count_u: got %0d want %0d", u_if0.out_count, popc(e.f0));
          end
          if (u_if1.out_flags !== e.f1) begin
            errors = errors + 1;
            $display("FAIL sb_flags_s: got %b want %b", u_if1.out_flags, e.f1);
          end
          if (u_if1.out_count !== 3'(popc(e.f1))) begin
            errors = errors + 1;
            $display("FAIL sb_count_s: got %0d want %0d", u_if1.out_count, popc(e.f1));
          end
        end
      end
      if (in_valid && u_if0.in_ready) begin
        exp_t n;
        n.f0 = model_flags(in_a, in_b, in_mode, 1'b0);
        n.f1 = model_flags(in_a, in_b, in_mode, 1'b1);
        exp_q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still outstanding, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    #12;
    checks += 3;
    if (u_if0.out_valid !== 1'b0 || u_if1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b want 0/0", u_if0.out_valid, u_if1.out_valid);
    end
    if (u_if0.out_flags !== 4'b0 || u_if1.out_flags !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b/%b want 0000", u_if0.out_flags, u_if1.out_flags);
    end
    if (u_if0.out_count !== 3'd0 || u_if1.out_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d want 0", u_if0.out_count, u_if1.out_count);
    end
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (u_if0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", u_if0.in_ready);
    end
  endtask

  task automatic test_basic_gt();
    in_valid  = 1'b1;
    in_a      = {3'd7, 3'd0, 3'd4, 3'd5};
    in_b      = {3'd6, 3'd0, 3'd4, 3'd3};
    in_mode   = 2'b00;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (u_if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gt_latency_early: out_valid got %b want 0 after 1 cycle", u_if0.out_valid);
    end
    tick();
    checks += 3;
    if (u_if0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gt_latency: out_valid got %b want 1 after 2 cycles", u_if0.out_valid);
    end
    if (u_if0.out_flags !== 4'b1001) begin
      errors++;
      $display("FAIL gt_flags: got %b want 1001", u_if0.out_flags);
    end
    if (u_if0.out_count !== 3'd2) begin
      errors++;
      $display("FAIL gt_count: got %0d want 2", u_if0.out_count);
    end
    wait_drain("gt");
  endtask

  task automatic test_back_to_back_modes();
    logic [1:0] modes [4];
    logic [3:0] want_f[4];
    logic [2:0] want_c[4];
    modes  = '{2'b00, 2'b10, 2'b01, 2'b11};
    want_f = '{4'b1001, 4'b0110, 4'b1111, 4'b0000};
    want_c = '{3'd2, 3'd2, 3'd4, 3'd0};
    in_a = {3'd7, 3'd0, 3'd4, 3'd5};
    in_b = {3'd6, 3'd0, 3'd4, 3'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      if (i < 4) in_mode = modes[i];
      if (i >= 2) begin
        checks += 3;
        if (u_if0.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL modes_valid[%0d]: got %b want 1", i - 2, u_if0.out_valid);
        end
        if (u_if0.out_flags !== want_f[i-2]) begin
          errors++;
          $display("FAIL modes_flags[%0d]: got %b want %b", i - 2, u_if0.out_flags, want_f[i-2]);
        end
        if (u_if0.out_count !== want_c[i-2]) begin
          errors++;
          $display("FAIL modes_count[%0d]: got %0d want %0d", i - 2, u_if0.out_count, want_c[i-2]);
        end
      end
      tick();
    end
    wait_drain("modes");
  endtask

  task automatic test_signed();
    logic [2:0] av[3];
    logic [2:0] bv[3];
    logic [1:0] mv[3];
    logic       want_s[3];
    logic       want_u[3];
    av = '{3'b100, 3'b100, 3'b111};
    bv = '{3'b011, 3'b011, 3'b110};
    mv = '{2'b00, 2'b11, 2'b00};
    want_s = '{1'b0, 1'b1, 1'b1};
    want_u = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin
        in_a    = {9'd0, av[i]};
        in_b    = {9'd0, bv[i]};
        in_mode = mv[i];
      end
      if (i >= 2) begin
        checks += 2;
        if (u_if1.out_valid !== 1'b1 || u_if1.out_flags[0] !== want_s[i-2]) begin
          errors++;
          $display("FAIL signed_flag0[%0d]: got v=%b f=%b want v=1 f=%b", i - 2,
                   u_if1.out_valid, u_if1.out_flags[0], want_s[i-2]);
        end
        if (u_if0.out_flags[0] !== want_u[i-2]) begin
          errors++;
          $display("FAIL unsigned_flag0[%0d]: got %b want %b", i - 2, u_if0.out_flags[0], want_u[i-2]);
        end
      end
      tick();
    end
    wait_drain("signed");
  endtask

  task automatic test_backpressure();
    logic [11:0] ba[4];
    logic [11:0] bb[4];
    logic [1:0]  bm[4];
    int idx;
    int n;
    for (int i = 0; i < 4; i++) begin
      ba[i] = 12'($urandom);
      bb[i] = 12'($urandom);
      bm[i] = 2'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_a = ba[idx];
      in_b = bb[idx];
      in_mode = bm[idx];
      @(negedge clk);
      if (in_valid && u_if0.in_ready) idx++;
      tick();
      if (c >= 2) begin
        checks += 3;
        if (u_if0.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready[%0d]: got %b want 0", c, u_if0.in_ready);
        end
        if (u_if0.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_out_valid[%0d]: got %b want 1", c, u_if0.out_valid);
        end
        if (exp_q.size() == 0 || u_if0.out_flags !== exp_q[0].f0) begin
          errors++;
          $display("FAIL bp_hold_flags[%0d]: got %b, head of model queue size %0d", c,
                   u_if0.out_flags, exp_q.size());
        end
      end
    end
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL bp_accepted: got %0d want 2", idx);
    end
    out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      in_valid = 1'b1;
      in_a = ba[idx];
      in_b = bb[idx];
      in_mode = bm[idx];
      @(negedge clk);
      if (in_valid && u_if0.in_ready) idx++;
      tick();
      n++;
    end
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL bp_resume: accepted %0d want 4", idx);
    end
    wait_drain("bp");
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 12'($urandom);
    in_b = 12'($urandom);
    in_mode = 2'($urandom);
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (u_if0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: out_valid got %b want 1", u_if0.out_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks += 2;
    if (u_if0.out_valid !== 1'b0 || u_if1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_valid: got %b/%b want 0/0", u_if0.out_valid, u_if1.out_valid);
    end
    if (u_if0.out_count !== 3'd0 || u_if0.out_flags !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_data: got flags=%b count=%0d want 0/0", u_if0.out_flags, u_if0.out_count);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (u_if0.out_valid !== 1'b0 || u_if1.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale[%0d]: got %b/%b want 0/0", c, u_if0.out_valid, u_if1.out_valid);
      end
    end
  endtask

  task automatic test_exhaustive();
    int j;
    int n;
    logic [2:0] a0;
    logic [2:0] b0;
    j = 0;
    n = 0;
    while (j < 256 && n < 4000) begin
      a0 = 3'(j / 32);
      b0 = 3'(j / 4);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      if (in_valid) begin
        in_a    = {9'($urandom), a0};
        in_b    = {9'($urandom), b0};
        in_mode = 2'(j);
      end else begin
        in_a    = 12'($urandom);
        in_b    = 12'($urandom);
        in_mode = 2'($urandom);
      end
      @(negedge clk);
      if (in_valid && u_if0.in_ready) j++;
      tick();
      n++;
    end
    checks++;
    if (j != 256) begin
      errors++;
      $display("FAIL exh_accepted: got %0d want 256", j);
    end
    wait_drain("exh");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_gt();
    test_back_to_back_modes();
    test_signed();
    test_backpressure();
    test_reset_midflight();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
